// File: rtl/expr_pkg.sv
// expr_pkg: shared types and ASCII constants for the streaming expression evaluator.
// Optional feature macro used by expr_calc: EXPR_CALC_MULTIDIGIT_EN.
package expr_pkg;

  // ASCII codes of the recognised characters
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  // Parser state
  typedef enum logic [1:0] {
    S_NUM  = 2'd0,
    S_OP   = 2'd1,
    S_SKIP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Character class seen by the parser
  typedef enum logic [2:0] {
    DIGIT   = 3'd0,
    PLUS    = 3'd1,
    MUL     = 3'd2,
    EQ      = 3'd3,
    ILLEGAL = 3'd4
  } char_class_t;

  // True for '0'..'9'
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// expr_char_class: combinational classifier mapping an ASCII byte to its
// character class and, for digits, the numeric value 0..9.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  i_char,
  output char_class_t o_cls_c,
  output logic [3:0]  o_digit_c
);

  // Classify the byte; anything outside digits and {+,*,=} is illegal
  always_comb begin
    o_cls_c   = ILLEGAL;
    o_digit_c = 4'd0;
    if (is_digit(i_char)) begin
      o_cls_c   = DIGIT;
      o_digit_c = 4'(i_char - CH_0);
    end else if (i_char == CH_PLUS) begin
      o_cls_c = PLUS;
    end else if (i_char == CH_MUL) begin
      o_cls_c = MUL;
    end else if (i_char == CH_EQ) begin
      o_cls_c = EQ;
    end
  end

endmodule

// File: rtl/expr_calc.sv
// expr_calc: streaming evaluator for infix expressions over '+' and '*'
// ('*' binds tighter), one ASCII character per handshake, result on '='.
// Optional feature: define EXPR_CALC_MULTIDIGIT_EN to let consecutive digits
// form one decimal operand; otherwise every operand is a single digit.
module expr_calc
  import expr_pkg::*;
#(
  parameter int unsigned WIDTH = 16
)
(
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  char_class_t      w_cls;
  logic [3:0]       w_digit;
  logic [WIDTH-1:0] w_digit_w;
  logic             w_accept;
  logic [WIDTH-1:0] w_term;

  state_t           r_state;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_prod;
  logic             r_bad;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             r_in_ready;
  logic             r_res_valid;

  expr_char_class u_char_class (
    .i_char    (in),
    .o_cls_c   (w_cls),
    .o_digit_c (w_digit)
  );

  assign w_digit_w = WIDTH'(w_digit);
  assign w_accept  = in_valid & r_in_ready;

`ifdef EXPR_CALC_MULTIDIGIT_EN
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] w_num_next;

  // Decimal accumulation of the operand currently being typed
  assign w_num_next = WIDTH'(WIDTH'(r_num * TEN) + w_digit_w);
  // Pending product term once the current operand is folded in
  assign w_term     = WIDTH'(r_prod * r_num);
`else
  // Single-digit operands are folded into prod as soon as they arrive
  assign w_term     = r_prod;
`endif

  // Parser FSM plus sum/product datapath; all outputs registered
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_NUM;
      r_sum       <= '0;
      r_prod      <= WIDTH'(1);
      r_bad       <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
`ifdef EXPR_CALC_MULTIDIGIT_EN
      r_num       <= '0;
`endif
    end else begin
      case (r_state)
        // Expecting an operand
        S_NUM: begin
          if (w_accept) begin
            case (w_cls)
              DIGIT: begin
`ifdef EXPR_CALC_MULTIDIGIT_EN
                r_num   <= w_digit_w;
`else
                r_prod  <= WIDTH'(r_prod * w_digit_w);
`endif
                r_state <= S_OP;
              end
              EQ: begin
                // Empty expression or trailing operator
                r_bad       <= 1'b1;
                r_result    <= '0;
                r_err       <= 1'b1;
                r_in_ready  <= 1'b0;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end
              default: begin
                r_bad   <= 1'b1;
                r_state <= S_SKIP;
              end
            endcase
          end
        end

        // Expecting an operator (or another digit in multi-digit builds)
        S_OP: begin
          if (w_accept) begin
            case (w_cls)
              PLUS: begin
                r_sum   <= WIDTH'(r_sum + w_term);
                r_prod  <= WIDTH'(1);
`ifdef EXPR_CALC_MULTIDIGIT_EN
                r_num   <= '0;
`endif
                r_state <= S_NUM;
              end
              MUL: begin
                r_prod  <= w_term;
`ifdef EXPR_CALC_MULTIDIGIT_EN
                r_num   <= '0;
`endif
                r_state <= S_NUM;
              end
              EQ: begin
                r_result    <= WIDTH'(r_sum + w_term);
                r_err       <= 1'b0;
`ifdef EXPR_CALC_MULTIDIGIT_EN
                r_num       <= '0;
`endif
                r_in_ready  <= 1'b0;
                r_res_valid <= 1'b1;
                r_state     <= S_DONE;
              end
`ifdef EXPR_CALC_MULTIDIGIT_EN
              DIGIT: begin
                r_num <= w_num_next;
              end
`endif
              default: begin
                r_bad   <= 1'b1;
                r_state <= S_SKIP;
              end
            endcase
          end
        end

        // Malformed expression: swallow characters until the terminator
        S_SKIP: begin
          if (w_accept && (w_cls == EQ)) begin
            r_result    <= '0;
            r_err       <= r_bad;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        // Result presented; restart once the consumer takes it
        S_DONE: begin
          if (res_ready) begin
            r_sum       <= '0;
            r_prod      <= WIDTH'(1);
            r_bad       <= 1'b0;
`ifdef EXPR_CALC_MULTIDIGIT_EN
            r_num       <= '0;
`endif
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_state     <= S_NUM;
          end
        end

        default: begin
          r_in_ready  <= 1'b1;
          r_res_valid <= 1'b0;
          r_state     <= S_NUM;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: doc/expr_calc.md
# expr_calc

Streaming evaluator for the single-digit infix expressions our `expr` recognizer accepts, such as `1+2*3`. It consumes one ASCII character per valid/ready handshake, checks syntax, and evaluates with `*` binding tighter than `+`. On the `=` terminator it presents the result and an error flag through an output handshake. It sits between a character source (UART or testbench) and any consumer of the computed value, and it sequences the sum/product datapath.

## Interface
- `WIDTH`, 16: width of the result and the internal sum/product registers; all arithmetic is mod 2^WIDTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  `in` holds a character.
- `in_ready`  out  1  block accepts a character this cycle.
- `in`  in  8  ASCII character.
- `res_valid`  out  1  `result`/`err` are valid.
- `res_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  expression value; 0 when `err`=1.
- `err`  out  1  expression was malformed.

## Operation
- A character is accepted when `in_valid & in_ready` at a rising edge. A result is taken when `res_valid & res_ready`.
- Registers:
  - `sum` resets to 0.
  - `prod` resets to 1.
  - `bad` resets to 0.
- States (reset state is S_NUM):
  - **S_NUM** (expect operand): on a digit d, `prod <= prod*d` and go to S_OP. On anything else, set `bad` and go to S_SKIP. A `=` here also sets `bad` and goes straight to S_DONE.
  - **S_OP** (expect operator):
    - On `+`: `sum <= sum+prod`, `prod <= 1`, go to S_NUM.
    - On `*`: go to S_NUM with `prod` kept.
    - On `=`: latch `result <= sum+prod` and `err <= 0`, go to S_DONE.
    - On any other character: set `bad` and go to S_SKIP.
  - **S_SKIP**: discard characters until `=`. On `=`, `result <= 0`, `err <= 1`, go to S_DONE.
  - **S_DONE**: `res_valid=1`. On `res_ready`, clear `sum`/`prod`/`bad` to their reset values and go to S_NUM.
- `in_ready` = 1 in S_NUM, S_OP and S_SKIP; 0 in S_DONE.
- Digits are `'0'`–`'9'`, value = `in - 8'h30`. Every other byte outside `{+,*,=}` is illegal.
- Products and sums are truncated to WIDTH bits at each step. There is no overflow indication.
- An empty expression (`=` as the first character) and a trailing operator (`1+=`) both give `err=1`.

## Timing
- Reset values:
  - `in_ready`=1
  - `res_valid`=0
  - `result`=0
  - `err`=0
- Accepting `=` makes `res_valid` rise on the next edge, i.e. one cycle of latency.
- `result` and `err` are registered and stay stable while `res_valid=1 & res_ready=0`.
- `res_ready` asserted in the first S_DONE cycle returns the block to S_NUM at the next edge. `in_ready` goes high in that same cycle, so there is no bubble beyond the single done cycle.
- `in_valid` ignored when `in_ready=0`; no character lost or duplicated.
- `clr` mid-expression or during S_DONE discards all partial state. `res_valid` drops asynchronously.

## Configuration
- `EXPR_CALC_MULTIDIGIT_EN`
  - **Defined:** consecutive digits form a decimal operand. A held register `num <= num*10+d` accumulates in the S_OP-side digit state. An operator or `=` first does `prod <= prod*num`, then clears `num`.
  - **Undefined:** a digit in S_OP is illegal (`bad`, S_SKIP), and there is no `num` register.
- The handshake and the other states are identical in both builds.

## Structure
- Package `expr_pkg` holds:
  - the state enum (S_NUM, S_OP, S_SKIP, S_DONE);
  - the ASCII constants `CH_PLUS`, `CH_MUL`, `CH_EQ`, `CH_0`, `CH_9`;
  - a `char_class_t` enum (DIGIT, PLUS, MUL, EQ, ILLEGAL).
- One combinational sub-module, `expr_char_class`: maps `in` to `char_class_t` and the digit value. The FSM and datapath stay in `expr_calc`.

## Test plan
- Feed `1+2*3=` with `res_ready=1` → `res_valid` one cycle after `=`, `result=7`, `err=0`. Then feed `2*3*4+5=` → `result=29`.
- Feed `1++2=` and also `=` alone → `err=1`, `result=0` for each. Characters after the first error are all accepted (`in_ready=1`) until `=`.
- WIDTH=4, feed `9*9+8=` → `result=(81+8) mod 16=9`, `err=0`.
- Hold `res_ready=0` for 3 cycles after `3*3=` → `in_ready=0`, `result=9` stable, and an offered `in_valid` character is not consumed. Raising `res_ready` returns the block to S_NUM.
- Assert `clr` between the `+` and the `2` of `1+2=`, then feed `4=` → `result=4`. The result is unaffected by the earlier `1`.
- Feed `12+3=`:
  - with `EXPR_CALC_MULTIDIGIT_EN` → `result=15`, `err=0`;
  - without it → `err=1`.
